// File: rtl/alu_mdu_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu_unit_if
// Purpose  : Request/response bundle between the issue stage and alu_mdu_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mdu_unit_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [1:0]      ALUop;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, op, funct3, funct7, ALUop, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, funct3, funct7, ALUop, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu_unit
// Purpose  : RV32I ALU + RV32M iterative multiply/divide behind valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mdu_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_mdu_unit_if.slave bus
);
    localparam int              c_SW   = $clog2(XLEN);
    localparam logic [c_SW-1:0] c_LAST = c_SW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;
    logic [c_SW-1:0]   r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [2:0]        r_funct3;
    logic              r_neg;
    logic              r_rneg;

    logic                   w_in_ready;
    logic                   w_accept;
    logic [c_SW-1:0]        w_shamt;
    logic signed [XLEN-1:0] w_sra;
    logic [XLEN-1:0]        w_alu;
    logic                   w_is_mop;
    logic                   w_div;
    logic                   w_dsigned;
    logic                   w_byzero;
    logic                   w_ovf;
    logic                   w_special;
    logic [XLEN-1:0]        w_special_res;
    logic [XLEN-1:0]        w_comb;
    logic                   w_iter;
    logic                   w_a_sgn;
    logic                   w_b_sgn;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [XLEN-1:0]        w_a_mag;
    logic [XLEN-1:0]        w_b_mag;
    logic [XLEN:0]          w_sum;
    logic [XLEN:0]          w_rs;
    logic [XLEN:0]          w_diff;
    logic [2*XLEN-1:0]      w_acc_next;
    logic [2*XLEN-1:0]      w_prod_fix;
    logic [XLEN-1:0]        w_quo;
    logic [XLEN-1:0]        w_rem;
    logic [XLEN-1:0]        w_fix;

    assign w_in_ready = !reset && ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;

    assign w_shamt = bus.src_b[c_SW-1:0];
    assign w_sra   = $signed(bus.src_a) >>> w_shamt;

    always_comb begin
        w_alu = '0;
        case (bus.ALUop)
            2'b00: w_alu = bus.src_a + bus.src_b;
            2'b01: w_alu = bus.src_a - bus.src_b;
            2'b10: begin
                case (bus.funct3)
                    3'b000: w_alu = (bus.op[5] && bus.funct7[5]) ? (bus.src_a - bus.src_b)
                                                                 : (bus.src_a + bus.src_b);
                    3'b001: w_alu = bus.src_a << w_shamt;
                    3'b010: w_alu = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
                    3'b011: w_alu = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
                    3'b100: w_alu = bus.src_a ^ bus.src_b;
                    3'b101: w_alu = bus.funct7[5] ? w_sra : (bus.src_a >> w_shamt);
                    3'b110: w_alu = bus.src_a | bus.src_b;
                    default: w_alu = bus.src_a & bus.src_b;
                endcase
            end
            default: w_alu = '0;
        endcase
    end

    // Divide-by-zero and signed overflow bypass the iterative datapath entirely.
    assign w_is_mop  = (bus.ALUop == 2'b10) && (bus.op == 7'b0110011) && (bus.funct7 == 7'b0000001);
    assign w_div     = bus.funct3[2];
    assign w_dsigned = !bus.funct3[0];
    assign w_byzero  = (bus.src_b == '0);
    assign w_ovf     = w_dsigned && (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src_b == '1);
    assign w_special = w_div && (w_byzero || w_ovf);
    assign w_iter    = w_is_mop && !w_special;

    always_comb begin
        if (bus.funct3[1]) w_special_res = w_byzero ? bus.src_a : '0;
        else               w_special_res = w_byzero ? '1 : bus.src_a;
    end

    assign w_comb = w_is_mop ? w_special_res : w_alu;

    assign w_a_sgn = w_div ? w_dsigned : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
    assign w_b_sgn = w_div ? w_dsigned : (bus.funct3[1:0] == 2'b01);
    assign w_a_neg = w_a_sgn && bus.src_a[XLEN-1];
    assign w_b_neg = w_b_sgn && bus.src_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -bus.src_a : bus.src_a;
    assign w_b_mag = w_b_neg ? -bus.src_b : bus.src_b;

    // r_acc: multiply shifts right (product high | multiplier low);
    // divide shifts left (partial remainder high | dividend/quotient low).
    always_comb begin
        w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_rs   = r_acc[2*XLEN-1:XLEN-1];
        w_diff = w_rs - {1'b0, r_opnd};
        if (r_funct3[2]) begin
            w_acc_next = w_diff[XLEN] ? {w_rs[XLEN-1:0],   r_acc[XLEN-2:0], 1'b0}
                                      : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_acc_next = {w_sum, r_acc[XLEN-1:1]};
        end
    end

    assign w_prod_fix = r_neg ? -w_acc_next : w_acc_next;
    assign w_quo      = w_acc_next[XLEN-1:0];
    assign w_rem      = w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        case (r_funct3)
            3'b000:                 w_fix = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix = r_neg ? -w_quo : w_quo;
            default:                w_fix = r_rneg ? -w_rem : w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_funct3 <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
        end else begin
            case (r_state)
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_result <= w_fix;
                        r_zero   <= (w_fix == '0);
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (w_iter) begin
                            r_state  <= S_CALC;
                            r_cnt    <= '0;
                            r_acc    <= {{XLEN{1'b0}}, (w_div ? w_a_mag : w_b_mag)};
                            r_opnd   <= w_div ? w_b_mag : w_a_mag;
                            r_funct3 <= bus.funct3;
                            r_neg    <= w_a_neg ^ w_b_neg;
                            r_rneg   <= w_a_neg;
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_comb;
                            r_zero   <= (w_comb == '0);
                        end
                    end else if ((r_state == S_DONE) && bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire
